// File: rtl/sample_ram_controller_pkg.sv
// sample_ram_controller_pkg: shared FSM encoding and buffer depth helper.
package sample_ram_controller_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sample_ram_controller_sdp_ram.sv
// sdp_ram: simple dual-port block RAM, one write port, registered 1-cycle read.
module sdp_ram
  import sample_ram_controller_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [depth_of(AW)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sample_ram_controller.sv
// sample_ram_controller: circular sample buffer streamed newest-N, oldest first, over rdy/eof/ack.
// Optional SAMPLE_RAM_FILL_TRACK_EN limits frames to locations actually written since reset.
module sample_ram_controller
  import sample_ram_controller_pkg::*;
#(
  parameter int BITS_ADC       = 8,
  parameter int RAM_ADDR_WIDTH = 9,
  parameter int REG_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [REG_DATA_WIDTH-1:0] num_samples,
  input  logic [BITS_ADC-1:0]       adc_data,
  input  logic                      adc_rdy,
  input  logic                      rqst_read,
  output logic [7:0]                tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int DEPTH = depth_of(AW);
  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         rem_q, rem_d, n_req, n;
  logic                wr_en;
  logic [BITS_ADC-1:0] ram_q;
  assign wr_en    = state_q == S_IDLE && we && adc_rdy;
  assign wr_ptr_d = wr_ptr_q + AW'(wr_en);
  assign n_req    = num_samples > REG_DATA_WIDTH'(DEPTH) ? (AW+1)'(DEPTH) : num_samples[AW:0];
`ifdef SAMPLE_RAM_FILL_TRACK_EN
  logic [AW:0] fill_q, fill_d;
  assign fill_d = fill_q + (AW+1)'(wr_en && fill_q != (AW+1)'(DEPTH));
  assign n      = n_req > fill_d ? fill_d : n_req;
  always_ff @(posedge clk) fill_q <= rst ? '0 : fill_d;
`else
  assign n = n_req;
`endif
  // wr_ptr_d already includes a same-cycle write, making that sample the newest in the frame
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    if (state_q == S_IDLE && rqst_read && n != '0) begin
      state_d  = S_FETCH;
      rd_ptr_d = wr_ptr_d - n[AW-1:0];
      rem_d    = n;
    end else if (state_q == S_FETCH) begin
      state_d = S_SEND;
    end else if (state_q == S_SEND && tx_ack) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rem_d    = rem_q - (AW+1)'(1);
      state_d  = rem_q == (AW+1)'(1) ? S_IDLE : S_FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
    end
  end
  sdp_ram #(.WIDTH(BITS_ADC), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(adc_data),
    .raddr(rd_ptr_q),
    .rdata(ram_q)
  );
  assign busy   = state_q != S_IDLE;
  assign tx_rdy = state_q == S_SEND;
  assign tx_eof = tx_rdy && rem_q == (AW+1)'(1);
  if (BITS_ADC >= 8) begin : g_trunc
    assign tx_data = tx_rdy ? ram_q[7:0] : 8'h00;
  end else begin : g_ext
    assign tx_data = tx_rdy ? 8'(ram_q) : 8'h00;
  end
endmodule

// File: tb/tb_sample_ram_controller.sv
// tb_sample_ram_controller: directed + randomized frames checked against an array model of the buffer.
module tb_sample_ram_controller;
  localparam int DEPTH = 512;
  logic        clk = 1'b0;
  logic        rst, we, adc_rdy, rqst_read, tx_ack;
  logic [15:0] num_samples;
  logic [7:0]  adc_data;
  logic [7:0]  tx_data;
  logic        tx_rdy, tx_eof, busy;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  mem [DEPTH];
  bit          valid [DEPTH];
  int          wp, fill;

  sample_ram_controller dut (
    .clk(clk), .rst(rst), .we(we), .num_samples(num_samples), .adc_data(adc_data),
    .adc_rdy(adc_rdy), .rqst_read(rqst_read), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .tx_eof(tx_eof), .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mwrite(input logic [7:0] d);
    mem[wp] = d;
    valid[wp] = 1'b1;
    wp = (wp + 1) % DEPTH;
    if (fill < DEPTH) fill++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wp = 0;
    fill = 0;
    foreach (valid[i]) valid[i] = 1'b0;
  endtask

  task automatic write_n(input int n, input bit rnd);
    int k = 0;
    while (k < n) begin
      we = 1'b1;
      adc_rdy = ($urandom % 4) != 0;
      adc_data = rnd ? 8'($urandom) : 8'(k);
      step();
      if (adc_rdy) begin
        mwrite(adc_data);
        k++;
      end
    end
    we = 1'b0;
    adc_rdy = 1'b0;
  endtask

  task automatic do_read(input int ns, input bit wsame, input logic [7:0] wd,
                         input int mind, input int maxd, input bit noise);
    int n, base, idx, d;
    num_samples = 16'(ns);
    rqst_read = 1'b1;
    if (wsame) begin
      we = 1'b1;
      adc_rdy = 1'b1;
      adc_data = wd;
    end
    step();
    rqst_read = 1'b0;
    we = 1'b0;
    adc_rdy = 1'b0;
    if (wsame) mwrite(wd);
    n = ns > DEPTH ? DEPTH : ns;
`ifdef SAMPLE_RAM_FILL_TRACK_EN
    if (n > fill) n = fill;
`endif
    if (n == 0) begin
      chk("zero_busy", busy, 0);
      chk("zero_rdy", tx_rdy, 0);
      return;
    end
    chk("fetch_rdy", tx_rdy, 0);
    chk("fetch_busy", busy, 1);
    base = (wp - n + DEPTH) % DEPTH;
    step();
    for (int i = 0; i < n; i++) begin
      idx = (base + i) % DEPTH;
      d = $urandom_range(mind, maxd);
      for (int j = 0; j <= d; j++) begin
        chk("send_rdy", tx_rdy, 1);
        chk("send_eof", tx_eof, i == n - 1);
        if (valid[idx]) chk("send_data", tx_data, mem[idx]);
        tx_ack = j == d;
        if (noise) begin
          we = 1'b1;
          adc_rdy = 1'b1;
          adc_data = 8'($urandom);
          rqst_read = $urandom % 2;
        end
        step();
      end
      tx_ack = 1'b0;
      we = 1'b0;
      adc_rdy = 1'b0;
      rqst_read = 1'b0;
      chk("gap_rdy", tx_rdy, 0);
      if (i == n - 1) chk("done_busy", busy, 0);
      else begin
        chk("gap_busy", busy, 1);
        step();
      end
    end
    step();
    chk("post_busy", busy, 0);
    chk("post_rdy", tx_rdy, 0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; adc_rdy = 1'b0; rqst_read = 1'b0; tx_ack = 1'b0;
    num_samples = '0; adc_data = '0;
    do_reset();
    chk("rst_rdy", tx_rdy, 0);
    chk("rst_eof", tx_eof, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    write_n(10, 1'b0);
    do_read(4, 1'b0, 8'h00, 0, 0, 1'b0);
    do_read(0, 1'b0, 8'h00, 0, 0, 1'b0);
    do_reset();
    write_n(520, 1'b0);
    chk("wrap_wp", wp, 8);
    do_read(600, 1'b0, 8'h00, 0, 0, 1'b0);
    do_read(7, 1'b0, 8'h00, 5, 5, 1'b1);
    do_read(1, 1'b1, 8'hAA, 0, 2, 1'b1);
    for (int r = 0; r < 6; r++) begin
      write_n($urandom_range(0, 40), 1'b1);
      do_read($urandom_range(0, 600), $urandom % 2, 8'($urandom), 0, 2, 1'b1);
    end
    do_reset();
    write_n(3, 1'b1);
    do_read(150, 1'b0, 8'h00, 0, 1, 1'b0);
    write_n(8, 1'b1);
    num_samples = 16'd4;
    rqst_read = 1'b1;
    step();
    rqst_read = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("abort_pre_rdy", tx_rdy, 1);
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      step();
    end
    do_reset();
    chk("abort_rdy", tx_rdy, 0);
    chk("abort_eof", tx_eof, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", tx_data, 0);
    write_n(4, 1'b1);
    do_read(4, 1'b0, 8'h00, 0, 2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_ram_controller.md
Name: sample_ram_controller

Overview:
- Downstream consumer of the trigger block. Stores one ADC channel's samples in a circular block-RAM buffer while the trigger block holds `we` high.
- On a request-handler read command, streams the most recent `num_samples` samples, oldest first, to the Tx protocol using the rdy/eof/ack handshake.
- The design instantiates one per channel.

Parameters:
- BITS_ADC, 8, sample width.
- RAM_ADDR_WIDTH, 9, buffer address width; DEPTH = 2**RAM_ADDR_WIDTH = 512.
- REG_DATA_WIDTH, 16, width of the num_samples register value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write enable from trigger block.
- num_samples  in  REG_DATA_WIDTH  samples to return per read.
- adc_data  in  BITS_ADC  sample from ADC.
- adc_rdy  in  1  adc_data valid this cycle.
- rqst_read  in  1  single-cycle read command from request handler.
- tx_data  out  8  sample to Tx, zero-extended or truncated to 8 bits.
- tx_rdy  out  1  tx_data valid.
- tx_eof  out  1  marks last sample of the frame; valid only with tx_rdy.
- tx_ack  in  1  Tx consumed tx_data.
- busy  out  1  read frame in progress.

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, remaining=0, state=IDLE. tx_rdy=0, tx_eof=0, tx_data=0, busy=0.
- Write: in IDLE, `we && adc_rdy` writes adc_data at wr_ptr; wr_ptr increments mod DEPTH (511 wraps to 0).
  - Writes are blocked in every state other than IDLE. The frame content is frozen.
- N = min(num_samples, DEPTH), computed in REG_DATA_WIDTH bits before truncation. num_samples is sampled on the rqst_read cycle only.
- States:
  - IDLE:
    - rqst_read with N=0 is ignored; no output.
    - rqst_read with N>0: rd_ptr = wr_ptr_next - N (mod DEPTH), remaining = N, go to FETCH.
    - wr_ptr_next includes a write occurring in the same cycle, so that sample is the newest in the frame.
  - FETCH: RAM read issued at rd_ptr (1-cycle read latency); go to SEND.
  - SEND:
    - tx_rdy=1 and tx_data=RAM output, both held stable until tx_ack.
    - tx_eof=1 when remaining==1.
    - On tx_ack: rd_ptr++ (mod DEPTH), remaining--. If that was the last sample, go to IDLE; otherwise go to FETCH.
    - tx_rdy therefore drops for exactly one cycle between samples.
- tx_ack while tx_rdy=0 is ignored.
- rqst_read while busy is ignored; it is not queued.
- busy = (state != IDLE).
- Latency: rqst_read to first tx_rdy is 2 cycles. Per-sample throughput is 1 per 2 cycles when tx_ack is returned immediately.
- N=DEPTH returns the entire buffer starting at wr_ptr, which is the oldest entry.
- rst mid-frame: abort immediately. All outputs return to reset values on the next cycle. RAM contents are undefined after reset.
- Samples from the trigger block's pretrigger and posttrigger windows are both covered, because the trigger block deasserts `we` at frame end.

Optional Feature:
- Macro SAMPLE_RAM_FILL_TRACK_EN.
- Defined:
  - Add a saturating fill counter, range 0..DEPTH, cleared by rst and incremented per accepted write.
  - N = min(num_samples, DEPTH, fill), so never-written locations are never sent.
  - If fill is 0, rqst_read is ignored.
- Undefined: no counter; N as above; stale or uninitialised locations may be sent.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, SEND) and the DEPTH derivation constant.
- One natural sub-module: sdp_ram, a simple dual-port RAM (BITS_ADC x DEPTH).
  - One write port and one read port, registered read with 1-cycle latency, block-RAM inferable, no reset on contents.
- The FSM and pointers stay in sample_ram_controller.

Test Plan:
- Basic read: reset; write 10 samples 0x00..0x09 with we=1; num_samples=4; rqst_read. Expect tx_data 0x06,0x07,0x08,0x09, tx_eof only on 0x09, then busy=0.
- Wrap-around: write 520 samples of value i&0xFF; num_samples=600 clamps N to 512. Expect 512 samples starting at value 8 (0x08), ending 0x07, with wr_ptr=8 after the writes.
- Backpressure: hold tx_ack=0 for 5 cycles during SEND. tx_data and tx_rdy must stay stable; writes during the frame must not change the streamed data.
- Simultaneous events: rqst_read in the same cycle as a write of 0xAA with num_samples=1. Expect a single sample 0xAA with tx_eof=1. A second rqst_read while busy produces no extra frame.
- Reset mid-frame: assert rst after the 2nd of 4 samples. Next cycle tx_rdy=0, tx_eof=0, busy=0; a following rqst_read is accepted normally.
- Fill tracking (SAMPLE_RAM_FILL_TRACK_EN): write 3 samples; num_samples=150. Expect exactly 3 samples with eof on the third. With the macro undefined, expect 150 samples.
